// File: rtl/out_ff_pkg.sv
// Shared constants and types for the out_ff output register.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package out_ff_pkg;

    localparam int OUT_FF_WIDTH_DEFAULT = 4;

    typedef logic [3:0] nibble_t;

    localparam nibble_t NIBBLE_ZERO = 4'b0000;

endpackage : out_ff_pkg

// File: rtl/out_ff_ff_d1.sv
// Single-bit D flip-flop with load enable and synchronous reset.
// Latency: one clk edge from d/enable/reset to q.
// Backpressure: none; enable=0 simply holds the stored bit.
module ff_d1 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next state: reset beats load, load beats hold.
    always_comb begin
        q_d = q_q;
        if (reset) begin
            q_d = RESET_VALUE;
        end else if (enable) begin
            q_d = d;
        end
    end

    // State register; reset is sampled only at the rising edge.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule : ff_d1

// File: rtl/out_ff.sv
// WIDTH-bit output register built from replicated ff_d1 bit cells.
// Latency: exactly one clk edge from D/enable/reset to Q; Q comes only from flops.
// Backpressure: none; enable=0 holds Q, reset overrides any pending load.
module out_ff
    import out_ff_pkg::*;
#(
    parameter int WIDTH       = OUT_FF_WIDTH_DEFAULT,
    parameter     RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Elaboration-time legality of the parameters.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("out_ff: WIDTH=%0d outside 1..32", WIDTH);
    end
    if ($bits(RESET_VALUE) != WIDTH) begin : g_bad_reset_value
        $error("out_ff: RESET_VALUE is %0d bits, WIDTH is %0d",
               $bits(RESET_VALUE), WIDTH);
    end

    localparam logic [WIDTH-1:0] RESET_VEC = RESET_VALUE;

    // One bit cell per data bit; all share the same strobes so every bit
    // loads, holds and resets on the same edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_d1 #(
            .RESET_VALUE (RESET_VEC[i])
        ) u_ff (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .d      (D[i]),
            .q      (Q[i])
        );
    end

    // Value the bank should present after the coming edge; used only to
    // check that Q does not move between edges.
    logic [WIDTH-1:0] q_expect_d;
    logic [WIDTH-1:0] q_expect_q;

    // Next-value selection in the same priority as the bit cells.
    always_comb begin
        q_expect_d = Q;
        if (reset) begin
            q_expect_d = RESET_VEC;
        end else if (enable) begin
            q_expect_d = D;
        end
    end

    // Snapshot of the value Q must keep until the next rising edge.
    always_ff @(posedge clk) begin
        q_expect_q <= q_expect_d;
    end

    a_reset_priority : assert property (@(posedge clk)
        reset |=> (Q == RESET_VEC))
        else $error("out_ff: Q not RESET_VALUE after reset edge");

    a_hold : assert property (@(posedge clk)
        (!reset && !enable) |=> $stable(Q))
        else $error("out_ff: Q changed with enable=0");

    a_stable_between_edges : assert property (@(negedge clk)
        (Q == q_expect_q))
        else $error("out_ff: Q moved between clock edges");

endmodule : out_ff

// File: tb/tb_out_ff.sv
// Directed bench for out_ff: reset, hold, loads, mid-cycle changes, priority.
// Latency: checks Q 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_out_ff;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] D;
    logic [3:0] Q;

    int tests;
    int fails;

    out_ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'b0000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .D      (D),
        .Q      (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; D = 4'b1010;
        tick();
        tests++;
        if (Q !== 4'b0000) begin
            fails++;
            $display("FAIL reset: Q=%b expected 0000", Q);
        end
    endtask

    task automatic test_hold();
        reset = 1'b0; enable = 1'b0; D = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (Q !== 4'b0000) begin
                fails++;
                $display("FAIL hold[%0d]: Q=%b expected 0000", i, Q);
            end
        end
    endtask

    task automatic test_load_sequence();
        logic [3:0] vec [3];
        vec[0] = 4'b0001; vec[1] = 4'b0010; vec[2] = 4'b0011;
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D = vec[i];
            tick();
            tests++;
            if (Q !== vec[i]) begin
                fails++;
                $display("FAIL load_seq[%0d]: Q=%b expected %b", i, Q, vec[i]);
            end
        end
    endtask

    task automatic test_mid_cycle();
        // Q is 0011 here; D changes twice inside one clock period.
        reset = 1'b0; enable = 1'b1; D = 4'b0101;
        #2;
        D = 4'b1111;
        #1;
        tests++;
        if (Q !== 4'b0011) begin
            fails++;
            $display("FAIL mid_cycle_before_edge: Q=%b expected 0011", Q);
        end
        enable = 1'b0;
        #1;
        enable = 1'b1;
        tick();
        tests++;
        if (Q !== 4'b1111) begin
            fails++;
            $display("FAIL mid_cycle_after_edge: Q=%b expected 1111", Q);
        end
    endtask

    task automatic test_priority();
        reset = 1'b0; enable = 1'b1; D = 4'b0011;
        tick();
        tests++;
        if (Q !== 4'b0011) begin
            fails++;
            $display("FAIL priority_setup: Q=%b expected 0011", Q);
        end
        reset = 1'b1; enable = 1'b1; D = 4'b1100;
        tick();
        tests++;
        if (Q !== 4'b0000) begin
            fails++;
            $display("FAIL priority_reset_wins: Q=%b expected 0000", Q);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (Q !== 4'b1100) begin
            fails++;
            $display("FAIL priority_resume: Q=%b expected 1100", Q);
        end
    endtask

    task automatic test_enable_drop();
        reset = 1'b0; enable = 1'b0; D = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (Q !== 4'b1100) begin
                fails++;
                $display("FAIL enable_drop_hold[%0d]: Q=%b expected 1100", i, Q);
            end
        end
        enable = 1'b1;
        tick();
        tests++;
        if (Q !== 4'b0110) begin
            fails++;
            $display("FAIL enable_drop_reload: Q=%b expected 0110", Q);
        end
    endtask

    task automatic test_reset_no_edge();
        // A reset pulse that starts and ends between edges leaves Q alone.
        reset = 1'b0; enable = 1'b1; D = 4'b0111;
        tick();
        enable = 1'b0;
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        tests++;
        if (Q !== 4'b0111) begin
            fails++;
            $display("FAIL reset_no_edge: Q=%b expected 0111", Q);
        end
    endtask

    task automatic test_back_to_back();
        // Every edge loads; covers all-ones, all-zeros and alternating bits.
        logic [3:0] vec [4];
        vec[0] = 4'b1111; vec[1] = 4'b0000; vec[2] = 4'b1010; vec[3] = 4'b0101;
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            D = vec[i];
            tick();
            tests++;
            if (Q !== vec[i]) begin
                fails++;
                $display("FAIL back_to_back[%0d]: Q=%b expected %b", i, Q, vec[i]);
            end
        end
        // Reset in the middle of a load stream, then loading resumes.
        reset = 1'b1; D = 4'b1001;
        tick();
        tests++;
        if (Q !== 4'b0000) begin
            fails++;
            $display("FAIL back_to_back_reset: Q=%b expected 0000", Q);
        end
        reset = 1'b0; D = 4'b1001;
        tick();
        tests++;
        if (Q !== 4'b1001) begin
            fails++;
            $display("FAIL back_to_back_resume: Q=%b expected 1001", Q);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        enable = 1'b0;
        D      = 4'b0000;
        #1;
        test_reset();
        test_hold();
        test_load_sequence();
        test_mid_cycle();
        test_priority();
        test_enable_drop();
        test_reset_no_edge();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_out_ff
